tinyalu_param: RTL and testbench

- Parametrised, next-generation ALU core for the tinyalu verification environment.
- Generalises the 8-bit tinyalu to WIDTH-bit operands.
- Keeps the start/done handshake and adds a busy output, a configurable pipelined multiplier, subtract and clear ops, and a zero flag.
- Sits under top as the DUT, driven by the tinyalu BFM interface signals.

---
 rtl/tinyalu_param.sv | 150 +++++++++++++++
 tb/tb_tinyalu_param.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/tinyalu_param.sv
// tinyalu_param: parametrised tinyalu core with a start/done handshake, a busy
// flag, a MUL_STAGES-deep multiplier pipeline, subtract/clear ops and a zero flag.
//
// Ports:
//   clk     rising-edge clock
//   reset   asynchronous, active-high reset
//   A, B    WIDTH-bit unsigned operands, captured when an op is accepted
//   op      3-bit operation code, captured when an op is accepted
//   start   level request; an op is accepted on an edge where start=1 and busy=0
//   busy    high while an operation is in flight
//   done    one-cycle completion pulse; result is valid in the same cycle
//   result  2*WIDTH-bit result, held until the next completion
//   zero    high when the last completed result is zero, held with result
//
// Op codes: 000 no_op, 001 add, 010 and, 011 xor, 100 mul, 101 sub,
//           110 reserved (no_op), 111 clr.
module tinyalu_param #(
  parameter int WIDTH      = 8,
  parameter int MUL_STAGES = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  input  logic [2:0]         op,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               zero
);

  localparam int RW = 2 * WIDTH;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_CLR = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SINGLE = 2'd1,
    MUL    = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  done_q, done_d;
  logic [RW-1:0]         result_q, result_d;
  logic                  zero_q, zero_d;
  logic [MUL_STAGES-1:0] vld_p, vld_d;

  logic                  accept, accept_single, accept_mul;
  logic [RW-1:0]         single_p0;
  logic [RW-1:0]         mul_p [MUL_STAGES];

  // Sign-extend the (WIDTH+1)-bit difference so a borrow shows as a negative pattern.
  function automatic logic [RW-1:0] sext_diff(input logic signed [WIDTH:0] d);
    return {{(WIDTH-1){d[WIDTH]}}, d};
  endfunction

  function automatic logic [RW-1:0] single_op(input logic [2:0]       o,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic        [WIDTH:0] sum;
    logic signed [WIDTH:0] diff;
    logic        [RW-1:0]  r;
    sum  = {1'b0, a} + {1'b0, b};
    diff = $signed({1'b0, a}) - $signed({1'b0, b});
    case (o)
      OP_ADD:  r = {{(WIDTH-1){1'b0}}, sum};
      OP_AND:  r = {{WIDTH{1'b0}}, a & b};
      OP_XOR:  r = {{WIDTH{1'b0}}, a ^ b};
      OP_SUB:  r = sext_diff(diff);
      default: r = '0;  // clr
    endcase
    return r;
  endfunction

  assign busy          = (state_q != IDLE);
  assign accept        = start && (state_q == IDLE);
  assign accept_single = accept && ((op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) ||
                                    (op == OP_SUB) || (op == OP_CLR));
  assign accept_mul    = accept && (op == OP_MUL);

  // Stage p0: single-cycle result and first multiplier stage captured at accept;
  // later multiplier stages only shift the product toward the result register.
  always_ff @(posedge clk) begin
    if (accept_single) single_p0 <= single_op(op, A, B);
    if (accept_mul)    mul_p[0]  <= RW'(A) * RW'(B);
    for (int i = 1; i < MUL_STAGES; i++) mul_p[i] <= mul_p[i-1];
  end

  always_comb begin
    vld_d    = '0;
    vld_d[0] = accept_mul;
    for (int i = 1; i < MUL_STAGES; i++) vld_d[i] = vld_p[i-1];
  end

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      IDLE: begin
        if (accept_mul)         state_d = MUL;
        else if (accept_single) state_d = SINGLE;
      end
      SINGLE: begin
        state_d  = IDLE;
        done_d   = 1'b1;
        result_d = single_p0;
        zero_d   = (single_p0 == '0);
      end
      MUL: begin
        if (vld_p[MUL_STAGES-1]) begin
          state_d  = IDLE;
          done_d   = 1'b1;
          result_d = mul_p[MUL_STAGES-1];
          zero_d   = (mul_p[MUL_STAGES-1] == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset aborts any in-flight op: clearing the valid bits and state means no late done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      vld_p    <= '0;
      done_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      vld_p    <= vld_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;

endmodule

// File: tb/tb_tinyalu_param.sv
module tb_tinyalu_param;

  localparam int W1 = 8;
  localparam int S1 = 3;
  localparam int W2 = 16;
  localparam int S2 = 1;

  logic clk = 1'b0;
  logic reset;

  logic [W1-1:0]   a1, b1;
  logic [2:0]      op1;
  logic            start1, busy1, done1, zero1;
  logic [2*W1-1:0] res1;

  logic [W2-1:0]   a2, b2;
  logic [2:0]      op2;
  logic            start2, busy2, done2, zero2;
  logic [2*W2-1:0] res2;

  tinyalu_param #(.WIDTH(W1), .MUL_STAGES(S1)) u_dut (
    .clk(clk), .reset(reset), .A(a1), .B(b1), .op(op1), .start(start1),
    .busy(busy1), .done(done1), .result(res1), .zero(zero1)
  );

  tinyalu_param #(.WIDTH(W2), .MUL_STAGES(S2)) u_dut2 (
    .clk(clk), .reset(reset), .A(a2), .B(b2), .op(op2), .start(start2),
    .busy(busy2), .done(done2), .result(res2), .zero(zero2)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [63:0] exp_res  [1:2];
  logic        exp_zero [1:2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular arithmetic on the 2*w-bit result space.
  function automatic logic [63:0] model(input int w, input logic [2:0] o,
                                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] a64, b64, r, m;
    a64 = {32'd0, a};
    b64 = {32'd0, b};
    m   = (64'd1 << (2 * w)) - 64'd1;
    case (o)
      3'b001:  r = a64 + b64;
      3'b010:  r = a64 & b64;
      3'b011:  r = a64 ^ b64;
      3'b100:  r = a64 * b64;
      3'b101:  r = a64 - b64;
      default: r = 64'd0;
    endcase
    return r & m;
  endfunction

  task automatic drive(input int inst, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] o, input logic s);
    if (inst == 1) begin
      a1 = a[W1-1:0]; b1 = b[W1-1:0]; op1 = o; start1 = s;
    end else begin
      a2 = a[W2-1:0]; b2 = b[W2-1:0]; op2 = o; start2 = s;
    end
  endtask

  function automatic logic [63:0] obs_res(input int inst);
    return (inst == 1) ? 64'(res1) : 64'(res2);
  endfunction
  function automatic logic obs_done(input int inst);
    return (inst == 1) ? done1 : done2;
  endfunction
  function automatic logic obs_busy(input int inst);
    return (inst == 1) ? busy1 : busy2;
  endfunction
  function automatic logic obs_zero(input int inst);
    return (inst == 1) ? zero1 : zero2;
  endfunction

  // One request: start for a single edge, scramble inputs afterwards, then watch
  // for exactly one done pulse at the expected latency.
  task automatic run_op(input string tag, input int inst, input logic [2:0] o,
                        input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    bit fin;
    int lat, first, pulses;
    fin    = !(o == 3'b000 || o == 3'b110);
    lat    = (o == 3'b100) ? ((inst == 1) ? S1 : S2) : 1;
    e      = model((inst == 1) ? W1 : W2, o, a, b);
    first  = 0;
    pulses = 0;
    @(negedge clk);
    drive(inst, a, b, o, 1'b1);
    @(negedge clk);
    drive(inst, ~a, b + 32'd1, 3'b111, 1'b0);
    check({tag, "/busy_after_accept"}, 64'(obs_busy(inst)), 64'(fin));
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      if (obs_done(inst)) begin
        pulses++;
        if (first == 0) begin
          first = k;
          check({tag, "/result"}, obs_res(inst), e);
          check({tag, "/zero"}, 64'(obs_zero(inst)), 64'(e == 64'd0));
          check({tag, "/busy_at_done"}, 64'(obs_busy(inst)), 64'd0);
        end
      end else if (fin && first == 0 && k < lat) begin
        check({tag, "/busy_in_flight"}, 64'(obs_busy(inst)), 64'd1);
      end
    end
    if (fin) begin
      check({tag, "/latency"}, 64'(first), 64'(lat));
      check({tag, "/done_pulses"}, 64'(pulses), 64'd1);
      exp_res[inst]  = e;
      exp_zero[inst] = (e == 64'd0);
    end else begin
      check({tag, "/no_done"}, 64'(pulses), 64'd0);
      check({tag, "/result_held"}, obs_res(inst), exp_res[inst]);
      check({tag, "/zero_held"}, 64'(obs_zero(inst)), 64'(exp_zero[inst]));
      check({tag, "/idle"}, 64'(obs_busy(inst)), 64'd0);
    end
  endtask

  initial begin
    int d_first, d_second, hits;
    logic [31:0] ra, rb;
    logic [2:0]  ro;

    reset = 1'b1;
    drive(1, 0, 0, 3'b000, 1'b0);
    drive(2, 0, 0, 3'b000, 1'b0);
    exp_res[1] = 64'd0; exp_zero[1] = 1'b1;
    exp_res[2] = 64'd0; exp_zero[2] = 1'b1;
    repeat (2) @(negedge clk);
    check("reset/done", 64'(done1), 64'd0);
    check("reset/busy", 64'(busy1), 64'd0);
    check("reset/result", 64'(res1), 64'd0);
    check("reset/zero", 64'(zero1), 64'd1);
    check("reset/result2", 64'(res2), 64'd0);
    reset = 1'b0;

    // Directed cases
    run_op("add_ff_01", 1, 3'b001, 32'hFF, 32'h01);
    check("add_ff_01/value", exp_res[1], 64'h0100);
    run_op("rsv_110", 1, 3'b110, 32'h12, 32'h34);
    run_op("clr", 1, 3'b111, 32'h12, 32'h34);
    run_op("nop_000", 1, 3'b000, 32'h56, 32'h78);
    run_op("mul_ff_ff", 1, 3'b100, 32'hFF, 32'hFF);
    check("mul_ff_ff/value", exp_res[1], 64'hFE01);
    run_op("mul_s1", 2, 3'b100, 32'hFF, 32'hFF);
    run_op("mul_w16", 2, 3'b100, 32'hFFFF, 32'hFFFF);
    check("mul_w16/value", exp_res[2], 64'hFFFE0001);
    run_op("sub_3_5", 1, 3'b101, 32'd3, 32'd5);
    check("sub_3_5/value", exp_res[1], 64'hFFFE);
    run_op("sub_w16", 2, 3'b101, 32'd0, 32'hFFFF);
    run_op("xor_5a", 1, 3'b011, 32'h5A, 32'h5A);
    run_op("and_f0_0f", 1, 3'b010, 32'hF0, 32'h0F);
    run_op("add_max_w16", 2, 3'b001, 32'hFFFF, 32'hFFFF);

    // start held through a mul with op switched to add: add waits for the idle edge
    @(negedge clk);
    drive(1, 32'h0D, 32'h0B, 3'b100, 1'b1);
    @(negedge clk);
    drive(1, 32'h80, 32'h81, 3'b001, 1'b1);
    d_first = 0; d_second = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == S1 + 1) drive(1, 32'h80, 32'h81, 3'b001, 1'b0);
      if (done1) begin
        if (d_first == 0) begin
          d_first = k;
          check("hold/mul_result", 64'(res1), 64'd143);
        end else if (d_second == 0) begin
          d_second = k;
          check("hold/add_result", 64'(res1), 64'h101);
        end
      end
    end
    check("hold/mul_done_time", 64'(d_first), 64'(S1));
    check("hold/add_done_time", 64'(d_second), 64'(S1 + 2));
    exp_res[1] = 64'h101; exp_zero[1] = 1'b0;

    // Reset during cycle 1 of a mul
    run_op("add_pre_reset", 1, 3'b001, 32'h21, 32'h43);
    @(negedge clk);
    drive(1, 32'hC3, 32'h3C, 3'b100, 1'b1);
    @(negedge clk);
    drive(1, 32'hC3, 32'h3C, 3'b100, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid/busy", 64'(busy1), 64'd0);
    check("rst_mid/done", 64'(done1), 64'd0);
    check("rst_mid/result", 64'(res1), 64'd0);
    check("rst_mid/zero", 64'(zero1), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    exp_res[1] = 64'd0; exp_zero[1] = 1'b1;
    exp_res[2] = 64'd0; exp_zero[2] = 1'b1;
    hits = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done1) hits++;
    end
    check("rst_mid/no_late_done", 64'(hits), 64'd0);
    check("rst_mid/result_after", 64'(res1), 64'd0);
    run_op("nop_after_reset", 1, 3'b000, 32'h11, 32'h22);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      run_op("rand_w8", 1, ro, ra & 32'hFF, rb & 32'hFF);
    end
    for (int i = 0; i < 20; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'hFFFF : $urandom;
      run_op("rand_w16", 2, ro, ra & 32'hFFFF, rb & 32'hFFFF);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
